// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//    Time-multiplexed hex display driver for a DIGITS-wide 7-segment display.
//    System logic presents a packed hex value and per-digit decimal points and
//    strobes load; the value sits in a shadow register until the next frame
//    boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//    clk         system clock, rising edge
//    rst         synchronous active-high reset
//    value       packed nibbles, nibble k is digit k (digit 0 least significant)
//    dp_in       decimal-point request per digit, captured with value
//    load        one-cycle strobe capturing value/dp_in into the shadow register
//    lz_en       level, enables leading-zero blanking
//    an          digit enables (one-hot when a digit is lit)
//    seg         segments, seg[0]=a .. seg[6]=g
//    dp          decimal point of the enabled digit
//    pending     shadow holds a load not yet displayed
//    frame_done  one-cycle pulse after each frame boundary
//
// an/seg/dp are inverted at the pins when ACTIVE_LOW=1; pending/frame_done never are.

module seg7_scan_driver #(
   parameter int DIGITS     = 4,
   parameter int CLK_DIV    = 1000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic                  lz_en,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  pending,
   output logic                  frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = $clog2(CLK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [PRE_W-1:0]     presc;
   logic [IDX_W-1:0]     idx;
   logic [4*DIGITS-1:0]  disp_val;
   logic [DIGITS-1:0]    disp_dp;
   logic [4*DIGITS-1:0]  shadow_val;
   logic [DIGITS-1:0]    shadow_dp;
   logic                 pending_r;
   logic                 frame_done_r;
   logic [DIGITS-1:0]    an_r;
   logic [6:0]           seg_r;
   logic                 dp_r;

   logic                 tick;
   logic                 boundary;
   logic [3:0]           cur_nib;
   logic                 cur_dp;
   logic                 blank;
   logic                 zero_above;
   logic [DIGITS-1:0]    an_next;
   logic [6:0]           seg_next;
   logic                 dp_next;

   // Glyph table written as the abcdefg strings; reordered so seg[0]=a.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return {s[0], s[1], s[2], s[3], s[4], s[5], s[6]};
   endfunction

   assign tick     = (presc == PRE_LAST);
   assign boundary = tick && (idx == IDX_LAST);

   // Walk from the top digit down so zero_above tells whether this digit and
   // every digit above it are zero; digit 0 is never blanked.
   always_comb begin
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      blank      = 1'b0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above && (disp_val[4*k +: 4] == 4'h0);
         if (idx == IDX_W'(k)) begin
            cur_nib = disp_val[4*k +: 4];
            cur_dp  = disp_dp[k];
            blank   = lz_en && (k != 0) && zero_above;
         end
      end
   end

   always_comb begin
      an_next  = '0;
      seg_next = '0;
      dp_next  = 1'b0;
      if (!blank) begin
         an_next  = DIGITS'(1) << idx;
         seg_next = glyph(cur_nib);
         dp_next  = cur_dp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc        <= '0;
         idx          <= '0;
         disp_val     <= '0;
         disp_dp      <= '0;
         shadow_val   <= '0;
         shadow_dp    <= '0;
         pending_r    <= 1'b0;
         frame_done_r <= 1'b0;
         an_r         <= '0;
         seg_r        <= '0;
         dp_r         <= 1'b0;
      end else begin
         frame_done_r <= boundary;

         if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end

         // Display takes the shadow as it stood before any same-cycle load.
         if (boundary && pending_r) begin
            disp_val <= shadow_val;
            disp_dp  <= shadow_dp;
         end

         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
            pending_r  <= 1'b1;
         end else if (boundary) begin
            pending_r  <= 1'b0;
         end

         an_r  <= an_next;
         seg_r <= seg_next;
         dp_r  <= dp_next;
      end
   end

   assign an         = an_r  ^ {DIGITS{ACTIVE_LOW}};
   assign seg        = seg_r ^ {7{ACTIVE_LOW}};
   assign dp         = dp_r  ^ ACTIVE_LOW;
   assign pending    = pending_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   // abcdefg glyph strings, converted to seg[0]=a ordering with rev()
   localparam logic [6:0] G0 = 7'b1111110;
   localparam logic [6:0] G1 = 7'b0110000;
   localparam logic [6:0] G2 = 7'b1101101;
   localparam logic [6:0] G3 = 7'b1111001;
   localparam logic [6:0] G5 = 7'b1011011;
   localparam logic [6:0] G7 = 7'b1110000;
   localparam logic [6:0] GA = 7'b1110111;
   localparam logic [6:0] GF = 7'b1000111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // main instance: DIGITS=4, CLK_DIV=4, active high
   logic        rst = 1'b1, load = 1'b0, lz_en = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp, pending, frame_done;

   // active-low instance
   logic        rst_al = 1'b1, load_al = 1'b0;
   logic [15:0] value_al = '0;
   logic [3:0]  dp_in_al = '0;
   logic [3:0]  an_al;
   logic [6:0]  seg_al;
   logic        dp_al, pending_al, frame_done_al;

   // single digit instance: DIGITS=1, CLK_DIV=2
   logic        rst1 = 1'b1, load1 = 1'b0;
   logic [3:0]  value1 = '0;
   logic [0:0]  dp_in1 = '0;
   logic [0:0]  an1;
   logic [6:0]  seg1;
   logic        dp1, pending1, frame_done1;

   seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .lz_en(lz_en),
      .an(an), .seg(seg), .dp(dp), .pending(pending), .frame_done(frame_done));

   seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst_al), .value(value_al), .dp_in(dp_in_al), .load(load_al), .lz_en(1'b0),
      .an(an_al), .seg(seg_al), .dp(dp_al), .pending(pending_al), .frame_done(frame_done_al));

   seg7_scan_driver #(.DIGITS(1), .CLK_DIV(2), .ACTIVE_LOW(1'b0)) dut1 (
      .clk(clk), .rst(rst1), .value(value1), .dp_in(dp_in1), .load(load1), .lz_en(1'b0),
      .an(an1), .seg(seg1), .dp(dp1), .pending(pending1), .frame_done(frame_done1));

   function automatic logic [6:0] rev(input logic [6:0] s);
      return {s[0], s[1], s[2], s[3], s[4], s[5], s[6]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
      step();
      rst = 1'b0; load = 1'b0; value = '0; dp_in = '0;
      checks++; if (an !== 4'b0000) begin failures++; $display("FAIL reset_an got=%b exp=0000", an); end
      checks++; if (seg !== 7'b0) begin failures++; $display("FAIL reset_seg got=%b exp=0000000", seg); end
      checks++; if (dp !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b exp=0", dp); end
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
      cyc = 0;
   endtask

   task automatic test_scan();
      int d;
      logic [3:0] ea;
      repeat (32) begin
         step();
         d = ((cyc - 1) / 4) % 4;
         ea = 4'(1 << d);
         checks++; if (an !== ea) begin failures++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, ea); end
         checks++; if (seg !== rev(G0)) begin failures++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", cyc, seg, rev(G0)); end
         checks++; if (frame_done !== (cyc % 16 == 0)) begin failures++; $display("FAIL scan_frame_done cyc=%0d got=%b", cyc, frame_done); end
      end
   endtask

   task automatic test_load();
      int d;
      logic [6:0] eg [4];
      eg[0] = rev(GF); eg[1] = rev(GA); eg[2] = rev(G2); eg[3] = rev(G1);
      repeat (4) step();
      value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
      step();
      load = 1'b0; value = '0; dp_in = '0;
      while (cyc < 48) begin
         checks++; if (pending !== 1'b1) begin failures++; $display("FAIL load_pending cyc=%0d got=%b exp=1", cyc, pending); end
         checks++; if (seg !== rev(G0)) begin failures++; $display("FAIL load_old_seg cyc=%0d got=%b exp=%b", cyc, seg, rev(G0)); end
         step();
      end
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL load_pending_clr got=%b exp=0", pending); end
      checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL load_frame_done got=%b exp=1", frame_done); end
      repeat (16) begin
         step();
         d = ((cyc - 1) / 4) % 4;
         checks++; if (an !== 4'(1 << d)) begin failures++; $display("FAIL load_an cyc=%0d got=%b", cyc, an); end
         checks++; if (seg !== eg[d]) begin failures++; $display("FAIL load_seg cyc=%0d got=%b exp=%b", cyc, seg, eg[d]); end
         checks++; if (dp !== (d == 2)) begin failures++; $display("FAIL load_dp cyc=%0d got=%b", cyc, dp); end
      end
   endtask

   task automatic test_back_to_back();
      step();
      value = 16'h1111; load = 1'b1;
      step();
      load = 1'b0;
      repeat (3) step();
      value = 16'h2222; load = 1'b1;
      step();
      load = 1'b0; value = '0;
      while (cyc < 80) begin
         checks++; if (pending !== 1'b1) begin failures++; $display("FAIL b2b_pending cyc=%0d got=%b exp=1", cyc, pending); end
         step();
      end
      repeat (16) begin
         step();
         checks++; if (seg !== rev(G2)) begin failures++; $display("FAIL b2b_seg cyc=%0d got=%b exp=%b", cyc, seg, rev(G2)); end
         checks++; if (dp !== 1'b0) begin failures++; $display("FAIL b2b_dp cyc=%0d got=%b exp=0", cyc, dp); end
      end
   endtask

   task automatic test_load_at_boundary();
      while (cyc < 111) step();
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL bnd_pending_pre got=%b exp=0", pending); end
      value = 16'h3333; load = 1'b1;
      step();
      load = 1'b0; value = '0;
      checks++; if (pending !== 1'b1) begin failures++; $display("FAIL bnd_pending_set got=%b exp=1", pending); end
      checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL bnd_frame_done got=%b exp=1", frame_done); end
      repeat (16) begin
         step();
         checks++; if (seg !== rev(G2)) begin failures++; $display("FAIL bnd_old_seg cyc=%0d got=%b exp=%b", cyc, seg, rev(G2)); end
         checks++; if (pending !== (cyc < 128)) begin failures++; $display("FAIL bnd_pending cyc=%0d got=%b", cyc, pending); end
      end
      repeat (16) begin
         step();
         checks++; if (seg !== rev(G3)) begin failures++; $display("FAIL bnd_new_seg cyc=%0d got=%b exp=%b", cyc, seg, rev(G3)); end
      end
   endtask

   task automatic test_lz();
      int d;
      logic [3:0] ea;
      logic [6:0] es;
      lz_en = 1'b1; value = 16'h0050; load = 1'b1;
      step();
      load = 1'b0; value = '0;
      while (cyc < 160) step();
      repeat (16) begin
         step();
         d = ((cyc - 1) / 4) % 4;
         ea = (d >= 2) ? 4'b0000 : 4'(1 << d);
         es = (d == 0) ? rev(G0) : (d == 1) ? rev(G5) : 7'b0;
         checks++; if (an !== ea) begin failures++; $display("FAIL lz50_an cyc=%0d got=%b exp=%b", cyc, an, ea); end
         checks++; if (seg !== es) begin failures++; $display("FAIL lz50_seg cyc=%0d got=%b exp=%b", cyc, seg, es); end
         checks++; if (dp !== 1'b0) begin failures++; $display("FAIL lz50_dp cyc=%0d got=%b exp=0", cyc, dp); end
      end
      value = 16'h0000; load = 1'b1;
      step();
      load = 1'b0;
      while (cyc < 192) step();
      repeat (16) begin
         step();
         d = ((cyc - 1) / 4) % 4;
         ea = (d == 0) ? 4'b0001 : 4'b0000;
         es = (d == 0) ? rev(G0) : 7'b0;
         checks++; if (an !== ea) begin failures++; $display("FAIL lz00_an cyc=%0d got=%b exp=%b", cyc, an, ea); end
         checks++; if (seg !== es) begin failures++; $display("FAIL lz00_seg cyc=%0d got=%b exp=%b", cyc, seg, es); end
      end
      lz_en = 1'b0;
   endtask

   task automatic test_active_low();
      step();
      checks++; if (an_al !== 4'b1111) begin failures++; $display("FAIL al_reset_an got=%b exp=1111", an_al); end
      checks++; if (seg_al !== 7'b1111111) begin failures++; $display("FAIL al_reset_seg got=%b exp=1111111", seg_al); end
      rst_al = 1'b0;
      repeat (2) step();
      value_al = 16'h1234; load_al = 1'b1;
      step();
      load_al = 1'b0;
      checks++; if (pending_al !== 1'b1) begin failures++; $display("FAIL al_pending got=%b exp=1", pending_al); end
      repeat (3) step();
      checks++; if (an_al !== 4'b1101) begin failures++; $display("FAIL al_scan_an got=%b exp=1101", an_al); end
      rst_al = 1'b1; value_al = 16'h5678; load_al = 1'b1;
      step();
      rst_al = 1'b0; load_al = 1'b0; value_al = '0;
      checks++; if (an_al !== 4'b1111) begin failures++; $display("FAIL al_rst_an got=%b exp=1111", an_al); end
      checks++; if (seg_al !== 7'b1111111) begin failures++; $display("FAIL al_rst_seg got=%b exp=1111111", seg_al); end
      checks++; if (dp_al !== 1'b1) begin failures++; $display("FAIL al_rst_dp got=%b exp=1", dp_al); end
      checks++; if (pending_al !== 1'b0) begin failures++; $display("FAIL al_rst_pending got=%b exp=0", pending_al); end
      checks++; if (frame_done_al !== 1'b0) begin failures++; $display("FAIL al_rst_frame_done got=%b exp=0", frame_done_al); end
      step();
      checks++; if (an_al !== 4'b1110) begin failures++; $display("FAIL al_restart_an got=%b exp=1110", an_al); end
      checks++; if (seg_al !== ~rev(G0)) begin failures++; $display("FAIL al_restart_seg got=%b exp=%b", seg_al, ~rev(G0)); end
      checks++; if (dp_al !== 1'b1) begin failures++; $display("FAIL al_restart_dp got=%b exp=1", dp_al); end
      repeat (16) step();
      checks++; if (an_al !== 4'b1110) begin failures++; $display("FAIL al_frame2_an got=%b exp=1110", an_al); end
      checks++; if (seg_al !== ~rev(G0)) begin failures++; $display("FAIL al_frame2_seg got=%b exp=%b", seg_al, ~rev(G0)); end
      checks++; if (pending_al !== 1'b0) begin failures++; $display("FAIL al_frame2_pending got=%b exp=0", pending_al); end
   endtask

   task automatic test_single_digit();
      rst1 = 1'b0; value1 = 4'h7; load1 = 1'b1;
      step();
      load1 = 1'b0; value1 = '0;
      checks++; if (an1 !== 1'b1) begin failures++; $display("FAIL sd_an got=%b exp=1", an1); end
      checks++; if (seg1 !== rev(G0)) begin failures++; $display("FAIL sd_seg0 got=%b exp=%b", seg1, rev(G0)); end
      checks++; if (pending1 !== 1'b1) begin failures++; $display("FAIL sd_pending got=%b exp=1", pending1); end
      checks++; if (frame_done1 !== 1'b0) begin failures++; $display("FAIL sd_fd1 got=%b exp=0", frame_done1); end
      step();
      checks++; if (frame_done1 !== 1'b1) begin failures++; $display("FAIL sd_fd2 got=%b exp=1", frame_done1); end
      checks++; if (pending1 !== 1'b0) begin failures++; $display("FAIL sd_pending_clr got=%b exp=0", pending1); end
      step();
      checks++; if (seg1 !== rev(G7)) begin failures++; $display("FAIL sd_seg7 got=%b exp=%b", seg1, rev(G7)); end
      checks++; if (frame_done1 !== 1'b0) begin failures++; $display("FAIL sd_fd3 got=%b exp=0", frame_done1); end
      step();
      checks++; if (frame_done1 !== 1'b1) begin failures++; $display("FAIL sd_fd4 got=%b exp=1", frame_done1); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load();
      test_back_to_back();
      test_load_at_boundary();
      test_lz();
      test_active_low();
      test_single_digit();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised successor to the single-digit BCD-to-7-segment decoder.
- Drives a DIGITS-wide common-anode or common-cathode multiplexed display from one packed hex value.
- Features: time-multiplexed digit scanning, a tear-free shadow-register load handshake, per-digit decimal points and optional leading-zero blanking.
- Sits between system logic (counters, FSM status) and the board display pins.

Parameters:
- DIGITS, 4: number of digits scanned; range 1..8.
- CLK_DIV, 1000: clk cycles each digit stays enabled; CLK_DIV >= 2.
- ACTIVE_LOW, 0: 1 inverts the an, seg and dp outputs for common-anode boards.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  4*DIGITS  packed nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
- dp_in  input  DIGITS  decimal-point request per digit, captured with value.
- load  input  1  one-cycle strobe; captures value and dp_in into the shadow register.
- lz_en  input  1  level; 1 enables leading-zero blanking.
- an  output  DIGITS  digit enables, one-hot when a digit is lit.
- seg  output  7  segments, seg[0]=a .. seg[6]=g.
- dp  output  1  decimal point of the currently enabled digit.
- pending  output  1  shadow holds a load not yet displayed.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Output polarity below is logical (1 = lit/enabled); with ACTIVE_LOW=1, an, seg and dp are inverted at the pins. pending and frame_done are never inverted.
- Reset (rst=1 at an edge) clears:
  - prescaler = 0, digit index idx = 0;
  - display and shadow registers = 0, pending = 0;
  - an = all inactive, seg = off, dp = off, frame_done = 0.
- Reset takes priority over everything, including a same-cycle load, and aborts any scan in progress.
- Prescaler counts 0..CLK_DIV-1 and wraps. A tick is prescaler == CLK_DIV-1; on a tick, idx advances by 1 and wraps from DIGITS-1 to 0.
- Frame boundary = tick while idx == DIGITS-1. At a frame boundary:
  - frame_done = 1 for exactly the next cycle;
  - if pending=1: display <= shadow and pending <= 0.
- Load handshake:
  - load=1 sets shadow <= {value, dp_in} and pending <= 1.
  - Repeated loads before a boundary overwrite shadow; the last one wins.
- Load coinciding with a frame boundary:
  - display takes the pre-load shadow contents, if pending was 1;
  - shadow takes the new value;
  - pending stays/becomes 1;
  - the new value is shown from the following frame.
- The display register never changes mid-frame, so digits never show a mix of old and new values.
- Decode: the nibble of display at idx is mapped to hexadecimal glyphs 0-9, A, b, C, d, E, F (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000;
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading-zero blanking (lz_en=1): digit k is blank when every nibble k..DIGITS-1 of display is 0. Digit 0 is never blanked, so value 0 shows "0".
  - A blank digit drives an all inactive and seg/dp off for its slot.
  - lz_en is sampled combinationally each cycle.
- Output timing: an, seg and dp are registered, with 1-cycle latency from idx/display.
  - Non-blank digit: an = one-hot(idx) and dp = the display dp bit of idx.
  - After reset release: cycle 1 shows digit 0 of display (= "0") on an[0].
- DIGITS=1: every tick is a frame boundary.

Test Plan:
- DIGITS=4, CLK_DIV=4, reset then idle 20 cycles -> an walks 0001, 0010, 0100, 1000 (4 cycles each, 1-cycle latency), seg=1111110 on all digits, frame_done pulses every 16 cycles.
- load value=16'h12AF, dp_in=4'b0100 mid-frame -> pending=1 until next frame_done; from the next frame, digits 0..3 show F, A, 2, 1, and dp=1 only while an=0100; pending=0 after the boundary.
- Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 appears; 1111 is never displayed.
- load 16'h3333 in the cycle of the frame boundary with pending=0 -> the current frame keeps the old value, 3333 shows one frame later, pending=1 in between.
- lz_en=1, value=16'h0050 -> digits 3 and 2 have an inactive and seg=0; digit 1 shows 5, digit 0 shows 0. Value 16'h0000 -> only digit 0 lit with "0".
- ACTIVE_LOW=1, rst asserted mid-scan with a same-cycle load -> an=1111, seg=1111111, dp=1, pending=0 next cycle; scan restarts at digit 0 with display 0.
